ibuf_pingpong_scheduler: RTL and testbench
==========================================

# ibuf_pingpong_scheduler

Tile scheduler in front of the on-chip input-buffer-to-PE controller. It tracks fill status of the two ping-pong input banks (A/B), sequences one tile at a time through the controller, and returns banks to the off-chip loader once their tiles are consumed. Per tile it holds the controller in reset, releases it with the proper buffer select / reload / start / read-enable, waits for `On_to_PE_finish`, then advances. It sits between the DRAM loader, the output-buffer ready flag and the input-buffer-to-PE controller.

## Interface
Parameters:
- `TILE_CNT_W`, 8, width of total-tile and tile-index counters
- `FILL_CNT_W`, 4, width of tiles-per-fill count

Ports:
- `clk` in 1: single clock, all logic rising-edge
- `Ibuf_Sched_rst` in 1: synchronous, active-high reset
- `layer_start` in 1: one-cycle pulse; latches config, starts layer (ignored while `busy`)
- `total_tiles` in TILE_CNT_W: tiles in the layer, sampled on `layer_start`
- `tiles_per_fill` in FILL_CNT_W: tiles per bank load, sampled on `layer_start`; 0 treated as 1
- `load_done_A`, `load_done_B` in 1: loader pulse, bank filled
- `obuf_ready` in 1: output buffer can accept a tile
- `On_to_PE_finish` in 1: controller tile-complete flag (level)
- `Input_Buffer_to_PE_Ctrl_rst` out 1: controller reset
- `start_A`, `start_B`, `ibuf_rd_A`, `ibuf_rd_B` out 1: controller start/read enables
- `On_to_PE_buffer_sel` out 1: 0 = bank A, 1 = bank B
- `Reload` out 1: first tile of a fresh fill
- `bank_full_A`, `bank_full_B` out 1: bank holds valid data
- `bank_free_A`, `bank_free_B` out 1: one-cycle release pulse to loader
- `tile_done` out 1: one-cycle pulse per completed tile
- `tile_index` out TILE_CNT_W: tiles completed this layer
- `layer_done` out 1: level, set at layer end, cleared by next `layer_start`
- `busy` out 1: FSM not in IDLE
- `ovf_err` out 1: sticky, `load_done_X` while bank X already full

## Operation
- States: IDLE, WAIT_BANK, CTRL_RST, RUN, TILE_END.
- IDLE: on `layer_start`, latch config, `tile_index`=0, fill counter=0, sel=0, `layer_done`=0 → WAIT_BANK. If `total_tiles`==0: `layer_done`=1, stay IDLE.
- WAIT_BANK: when `bank_full` of selected bank and `obuf_ready` → CTRL_RST.
- CTRL_RST: one cycle; `Reload`=1 iff fill counter==0 → RUN.
- RUN: `Input_Buffer_to_PE_Ctrl_rst`=0; `start_X`=`ibuf_rd_X`=1 for selected bank only. On `On_to_PE_finish`=1 → TILE_END.
- TILE_END: one cycle; `tile_done`=1; `tile_index`+1; fill counter+1. If fill counter+1==`tiles_per_fill` or `tile_index`+1==`total_tiles`: `bank_free_X` pulse, clear `bank_full_X`, fill counter=0, toggle sel. If `tile_index`+1==`total_tiles` → IDLE with `layer_done`=1; else → WAIT_BANK.
- `Input_Buffer_to_PE_Ctrl_rst`=1 in every state except RUN.
- `On_to_PE_buffer_sel` and `Reload` stable from CTRL_RST entry through TILE_END.
- `load_done_X` sets `bank_full_X` in any state (both banks may fill concurrently). Same-cycle clear (TILE_END) and `load_done_X`: set wins, no `ovf_err`.
- `load_done_X` with `bank_full_X`=1 and no same-cycle clear: `ovf_err`=1, flag unchanged.

## Timing
- Reset values: `Input_Buffer_to_PE_Ctrl_rst`=1, all other outputs 0, state IDLE, sel=0, flags clear.
- Reset mid-tile: next cycle IDLE, controller reset re-asserted, bank flags cleared, no `bank_free` pulse.
- All outputs registered or decoded from registered state; no combinational input→output paths.
- `layer_start` at cycle t → WAIT_BANK at t+1; earliest CTRL_RST t+2, RUN t+3.
- Tile overhead outside RUN: 2 cycles (CTRL_RST, TILE_END) plus any WAIT_BANK time.
- `On_to_PE_finish` is ignored outside RUN; the controller clears it during CTRL_RST so a stale value cannot end RUN early.
- `obuf_ready` sampled in WAIT_BANK only; deassertion during RUN does not stall.

## Test plan
- Reset, `layer_start` with total=4, per_fill=2, both banks preloaded, finish 10 cycles into each RUN → tiles on A,A,B,B; `Reload`=1 on tiles 0 and 2; `bank_free_A` at tile 1 TILE_END, `bank_free_B` at tile 3; `layer_done`=1, `tile_index`=4.
- Bank B not loaded after A releases → FSM holds WAIT_BANK with controller in reset; `load_done_B` → CTRL_RST next cycle.
- total=3, per_fill=2 → third tile on B frees B at its end (partial fill); `layer_done`=1.
- `load_done_A` twice without release → `ovf_err`=1; `load_done_A` same cycle as A's TILE_END release → `bank_full_A`=1, `ovf_err`=0.
- `Ibuf_Sched_rst` asserted mid-RUN → next cycle controller reset=1, `start_A`=0, `busy`=0, flags 0.
- total_tiles=0 → `layer_done`=1 one cycle after `layer_start`, no start pulses; `obuf_ready`=0 in WAIT_BANK → no CTRL_RST until it rises.

Source files
------------

// File: rtl/ibuf_pingpong_scheduler.sv
// Ping-pong input-bank tile scheduler: tracks bank fill status and walks
// one tile at a time through the input-buffer-to-PE controller.
module ibuf_pingpong_scheduler #(
    parameter int TILE_CNT_W = 8,
    parameter int FILL_CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  Ibuf_Sched_rst,
    input  logic                  layer_start,
    input  logic [TILE_CNT_W-1:0] total_tiles,
    input  logic [FILL_CNT_W-1:0] tiles_per_fill,
    input  logic                  load_done_A,
    input  logic                  load_done_B,
    input  logic                  obuf_ready,
    input  logic                  On_to_PE_finish,
    output logic                  Input_Buffer_to_PE_Ctrl_rst,
    output logic                  start_A,
    output logic                  start_B,
    output logic                  ibuf_rd_A,
    output logic                  ibuf_rd_B,
    output logic                  On_to_PE_buffer_sel,
    output logic                  Reload,
    output logic                  bank_full_A,
    output logic                  bank_full_B,
    output logic                  bank_free_A,
    output logic                  bank_free_B,
    output logic                  tile_done,
    output logic [TILE_CNT_W-1:0] tile_index,
    output logic                  layer_done,
    output logic                  busy,
    output logic                  ovf_err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BANK,
        CTRL_RST,
        RUN,
        TILE_END
    } state_t;

    state_t state, state_nxt;

    logic                  sel;
    logic [FILL_CNT_W-1:0] fill_cnt;
    logic [FILL_CNT_W-1:0] per_fill;
    logic [TILE_CNT_W-1:0] total_r;
    logic [TILE_CNT_W-1:0] tile_cnt;
    logic                  full_a;
    logic                  full_b;
    logic                  ovf;
    logic                  done_r;

    logic [TILE_CNT_W-1:0] tile_nxt;
    logic [FILL_CNT_W-1:0] fill_nxt;
    logic                  last_tile;
    logic                  release_bank;
    logic                  clr_a;
    logic                  clr_b;
    logic                  sel_ready;
    logic                  in_tile;

    assign tile_nxt     = tile_cnt + 1'b1;
    assign fill_nxt     = fill_cnt + 1'b1;
    assign last_tile    = (tile_nxt == total_r);
    assign release_bank = (state == TILE_END) &&
                          ((fill_nxt == per_fill) || last_tile);
    assign clr_a        = release_bank && !sel;
    assign clr_b        = release_bank && sel;
    assign in_tile      = (state == CTRL_RST) || (state == RUN) ||
                          (state == TILE_END);

    // A load landing this cycle counts as ready so CTRL_RST follows at once
    assign sel_ready = sel ? (full_b || load_done_B)
                           : (full_a || load_done_A);

    always_ff @(posedge clk) begin
        if (Ibuf_Sched_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (layer_start && (total_tiles != '0)) begin
                    state_nxt = WAIT_BANK;
                end
            end
            WAIT_BANK: begin
                if (sel_ready && obuf_ready) begin
                    state_nxt = CTRL_RST;
                end
            end
            CTRL_RST: state_nxt = RUN;
            RUN: begin
                if (On_to_PE_finish) begin
                    state_nxt = TILE_END;
                end
            end
            TILE_END: state_nxt = last_tile ? IDLE : WAIT_BANK;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Ibuf_Sched_rst) begin
            sel      <= 1'b0;
            fill_cnt <= '0;
            per_fill <= '0;
            total_r  <= '0;
            tile_cnt <= '0;
            done_r   <= 1'b0;
        end else begin
            if ((state == IDLE) && layer_start) begin
                total_r  <= total_tiles;
                per_fill <= (tiles_per_fill == '0) ? FILL_CNT_W'(1)
                                                   : tiles_per_fill;
                tile_cnt <= '0;
                fill_cnt <= '0;
                sel      <= 1'b0;
                done_r   <= (total_tiles == '0);
            end
            if (state == TILE_END) begin
                tile_cnt <= tile_nxt;
                fill_cnt <= release_bank ? '0 : fill_nxt;
                if (release_bank) begin
                    sel <= ~sel;
                end
                if (last_tile) begin
                    done_r <= 1'b1;
                end
            end
        end
    end

    // A fresh load coinciding with the release wins over the clear
    always_ff @(posedge clk) begin
        if (Ibuf_Sched_rst) begin
            full_a <= 1'b0;
            full_b <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (load_done_A) begin
                full_a <= 1'b1;
                if (full_a && !clr_a) begin
                    ovf <= 1'b1;
                end
            end else if (clr_a) begin
                full_a <= 1'b0;
            end
            if (load_done_B) begin
                full_b <= 1'b1;
                if (full_b && !clr_b) begin
                    ovf <= 1'b1;
                end
            end else if (clr_b) begin
                full_b <= 1'b0;
            end
        end
    end

    assign Input_Buffer_to_PE_Ctrl_rst = (state != RUN);
    assign start_A             = (state == RUN) && !sel;
    assign start_B             = (state == RUN) && sel;
    assign ibuf_rd_A           = (state == RUN) && !sel;
    assign ibuf_rd_B           = (state == RUN) && sel;
    assign On_to_PE_buffer_sel = sel;
    assign Reload              = in_tile && (fill_cnt == '0);
    assign bank_full_A         = full_a;
    assign bank_full_B         = full_b;
    assign bank_free_A         = clr_a;
    assign bank_free_B         = clr_b;
    assign tile_done           = (state == TILE_END);
    assign tile_index          = tile_cnt;
    assign layer_done          = done_r;
    assign busy                = (state != IDLE);
    assign ovf_err             = ovf;

endmodule

// File: tb/tb_ibuf_pingpong_scheduler.sv
// Directed bench for ibuf_pingpong_scheduler: tile sequencing, bank
// handoff, overflow, mid-tile reset and zero-tile layers.
module tb_ibuf_pingpong_scheduler;

    logic       clk;
    logic       Ibuf_Sched_rst;
    logic       layer_start;
    logic [7:0] total_tiles;
    logic [3:0] tiles_per_fill;
    logic       load_done_A;
    logic       load_done_B;
    logic       obuf_ready;
    logic       On_to_PE_finish;
    logic       Input_Buffer_to_PE_Ctrl_rst;
    logic       start_A;
    logic       start_B;
    logic       ibuf_rd_A;
    logic       ibuf_rd_B;
    logic       On_to_PE_buffer_sel;
    logic       Reload;
    logic       bank_full_A;
    logic       bank_full_B;
    logic       bank_free_A;
    logic       bank_free_B;
    logic       tile_done;
    logic [7:0] tile_index;
    logic       layer_done;
    logic       busy;
    logic       ovf_err;

    int total;
    int bad;

    ibuf_pingpong_scheduler #(
        .TILE_CNT_W(8),
        .FILL_CNT_W(4)
    ) dut (
        .clk                        (clk),
        .Ibuf_Sched_rst             (Ibuf_Sched_rst),
        .layer_start                (layer_start),
        .total_tiles                (total_tiles),
        .tiles_per_fill             (tiles_per_fill),
        .load_done_A                (load_done_A),
        .load_done_B                (load_done_B),
        .obuf_ready                 (obuf_ready),
        .On_to_PE_finish            (On_to_PE_finish),
        .Input_Buffer_to_PE_Ctrl_rst(Input_Buffer_to_PE_Ctrl_rst),
        .start_A                    (start_A),
        .start_B                    (start_B),
        .ibuf_rd_A                  (ibuf_rd_A),
        .ibuf_rd_B                  (ibuf_rd_B),
        .On_to_PE_buffer_sel        (On_to_PE_buffer_sel),
        .Reload                     (Reload),
        .bank_full_A                (bank_full_A),
        .bank_full_B                (bank_full_B),
        .bank_free_A                (bank_free_A),
        .bank_free_B                (bank_free_B),
        .tile_done                  (tile_done),
        .tile_index                 (tile_index),
        .layer_done                 (layer_done),
        .busy                       (busy),
        .ovf_err                    (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Enters from WAIT_BANK with the selected bank ready; 10 cycles in RUN
    task automatic do_tile(input logic sel, input logic rl,
                           input logic fa, input logic fb,
                           input logic [7:0] idx, input logic ld_a_end);
        tick();
        load_done_A = 1'b0;
        load_done_B = 1'b0;
        chk("crst_reload", Reload, rl);
        chk("crst_sel", On_to_PE_buffer_sel, sel);
        chk("crst_ctrl_rst", Input_Buffer_to_PE_Ctrl_rst, 1);
        tick();
        chk("run_start_a", start_A, !sel);
        chk("run_start_b", start_B, sel);
        chk("run_rd_a", ibuf_rd_A, !sel);
        chk("run_rd_b", ibuf_rd_B, sel);
        chk("run_ctrl_rst", Input_Buffer_to_PE_Ctrl_rst, 0);
        repeat (9) tick();
        chk("run_hold", Input_Buffer_to_PE_Ctrl_rst, 0);
        On_to_PE_finish = 1'b1;
        tick();
        On_to_PE_finish = 1'b0;
        load_done_A = ld_a_end;
        chk("end_tile_done", tile_done, 1);
        chk("end_free_a", bank_free_A, fa);
        chk("end_free_b", bank_free_B, fb);
        chk("end_reload", Reload, rl);
        chk("end_sel", On_to_PE_buffer_sel, sel);
        chk("end_ctrl_rst", Input_Buffer_to_PE_Ctrl_rst, 1);
        tick();
        load_done_A = 1'b0;
        chk("post_tile_index", tile_index, idx);
        chk("post_tile_done", tile_done, 0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        Ibuf_Sched_rst = 1'b1;
        layer_start = 1'b0;
        total_tiles = '0;
        tiles_per_fill = '0;
        load_done_A = 1'b0;
        load_done_B = 1'b0;
        obuf_ready = 1'b0;
        On_to_PE_finish = 1'b0;
        tick();
        tick();
        Ibuf_Sched_rst = 1'b0;
        chk("rst_ctrl_rst", Input_Buffer_to_PE_Ctrl_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_start_a", start_A, 0);
        chk("rst_sel", On_to_PE_buffer_sel, 0);
        chk("rst_index", tile_index, 0);
        chk("rst_layer_done", layer_done, 0);
        chk("rst_full_a", bank_full_A, 0);
        chk("rst_ovf", ovf_err, 0);

        // Layer 1: 4 tiles, 2 per fill, both banks preloaded
        obuf_ready = 1'b1;
        load_done_A = 1'b1;
        load_done_B = 1'b1;
        tick();
        load_done_A = 1'b0;
        load_done_B = 1'b0;
        chk("l1_full_a", bank_full_A, 1);
        chk("l1_full_b", bank_full_B, 1);
        total_tiles = 8'd4;
        tiles_per_fill = 4'd2;
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        chk("l1_busy", busy, 1);
        chk("l1_wait_ctrl_rst", Input_Buffer_to_PE_Ctrl_rst, 1);
        do_tile(0, 1, 0, 0, 8'd1, 0);
        do_tile(0, 0, 1, 0, 8'd2, 0);
        chk("l1_a_cleared", bank_full_A, 0);
        do_tile(1, 1, 0, 0, 8'd3, 0);
        do_tile(1, 0, 0, 1, 8'd4, 0);
        chk("l1_layer_done", layer_done, 1);
        chk("l1_idle", busy, 0);
        chk("l1_b_cleared", bank_full_B, 0);

        // Layer 2: B arrives late
        load_done_A = 1'b1;
        tick();
        load_done_A = 1'b0;
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        chk("l2_layer_done_clr", layer_done, 0);
        do_tile(0, 1, 0, 0, 8'd1, 0);
        do_tile(0, 0, 1, 0, 8'd2, 0);
        repeat (3) begin
            tick();
            chk("l2_wait_busy", busy, 1);
            chk("l2_wait_ctrl_rst", Input_Buffer_to_PE_Ctrl_rst, 1);
            chk("l2_wait_reload", Reload, 0);
        end
        load_done_B = 1'b1;
        do_tile(1, 1, 0, 0, 8'd3, 0);
        do_tile(1, 0, 0, 1, 8'd4, 0);
        chk("l2_layer_done", layer_done, 1);

        // Layer 3: partial final fill on B
        load_done_A = 1'b1;
        load_done_B = 1'b1;
        tick();
        load_done_A = 1'b0;
        load_done_B = 1'b0;
        total_tiles = 8'd3;
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        do_tile(0, 1, 0, 0, 8'd1, 0);
        do_tile(0, 0, 1, 0, 8'd2, 0);
        do_tile(1, 1, 0, 1, 8'd3, 0);
        chk("l3_layer_done", layer_done, 1);
        chk("l3_busy", busy, 0);
        chk("l3_full_b", bank_full_B, 0);

        // Overflow, then load coinciding with release
        load_done_A = 1'b1;
        tick();
        chk("ovf_first", ovf_err, 0);
        tick();
        load_done_A = 1'b0;
        chk("ovf_second", ovf_err, 1);
        chk("ovf_full_a", bank_full_A, 1);
        Ibuf_Sched_rst = 1'b1;
        tick();
        Ibuf_Sched_rst = 1'b0;
        chk("ovf_rst", ovf_err, 0);
        chk("ovf_rst_full", bank_full_A, 0);
        load_done_A = 1'b1;
        tick();
        load_done_A = 1'b0;
        total_tiles = 8'd1;
        tiles_per_fill = 4'd1;
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        do_tile(0, 1, 1, 0, 8'd1, 1);
        chk("race_full_a", bank_full_A, 1);
        chk("race_ovf", ovf_err, 0);
        chk("race_layer_done", layer_done, 1);

        // Reset mid-RUN
        total_tiles = 8'd2;
        tiles_per_fill = 4'd2;
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        tick();
        tick();
        chk("mr_start_a", start_A, 1);
        Ibuf_Sched_rst = 1'b1;
        tick();
        Ibuf_Sched_rst = 1'b0;
        chk("mr_ctrl_rst", Input_Buffer_to_PE_Ctrl_rst, 1);
        chk("mr_start_a_off", start_A, 0);
        chk("mr_busy", busy, 0);
        chk("mr_full_a", bank_full_A, 0);
        chk("mr_free_a", bank_free_A, 0);
        chk("mr_tile_done", tile_done, 0);

        // Zero-tile layer
        total_tiles = 8'd0;
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        chk("z_layer_done", layer_done, 1);
        chk("z_busy", busy, 0);
        chk("z_start_a", start_A, 0);

        // obuf_ready gating, tiles_per_fill of 0 acts as 1
        obuf_ready = 1'b0;
        load_done_A = 1'b1;
        load_done_B = 1'b1;
        tick();
        load_done_A = 1'b0;
        load_done_B = 1'b0;
        total_tiles = 8'd2;
        tiles_per_fill = 4'd0;
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        repeat (3) begin
            tick();
            chk("ob_wait_reload", Reload, 0);
            chk("ob_wait_busy", busy, 1);
            chk("ob_wait_ctrl_rst", Input_Buffer_to_PE_Ctrl_rst, 1);
        end
        obuf_ready = 1'b1;
        do_tile(0, 1, 1, 0, 8'd1, 0);
        do_tile(1, 1, 0, 1, 8'd2, 0);
        chk("ob_layer_done", layer_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
